// File: rtl/cpu_fetch_decode_alu.sv
// Fetch/decode/execute datapath of the 8-bit teaching CPU: 16x8 writable
// instruction memory with a reset-time default program, field decoder and ALU.
module cpu_fetch_decode_alu (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] pc,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic [7:0] operand1,
  input  logic [7:0] operand2,
  output logic [7:0] instruction,
  output logic [2:0] opcode,
  output logic [2:0] dest,
  output logic [2:0] src,
  output logic [7:0] alu_result,
  output logic       zero_flag,
  output logic       zero_flag_q
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_MUL = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MOV = 3'b101,
    OP_CMP = 3'b110,
    OP_COM = 3'b111
  } op_e;

  logic [7:0]  mem [16];
  logic [15:0] product;
  op_e         op;

  // Program image restored on every reset.
  function automatic logic [7:0] default_word(input logic [3:0] addr);
    case (addr)
      4'd0:    return 8'hB3;
      4'd1:    return 8'hB6;
      4'd2:    return 8'h01;
      4'd3:    return 8'h21;
      4'd4:    return 8'hC1;
      4'd5:    return 8'h41;
      4'd6:    return 8'h61;
      4'd7:    return 8'h81;
      4'd8:    return 8'hE0;
      4'd9:    return 8'hA1;
      4'd10:   return 8'h6C;
      default: return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 16; i++) begin
        mem[i] <= default_word(4'(i));
      end
    end else if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    instruction = mem[pc];
    opcode      = instruction[7:5];
    dest        = instruction[4:2];
    src         = {1'b0, instruction[1:0]};
    op          = op_e'(opcode);
  end

  assign product = 16'(operand1) * 16'(operand2);

  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD:  alu_result = operand1 + operand2;
      OP_MUL:  alu_result = product[7:0];
      OP_AND:  alu_result = operand1 & operand2;
      OP_OR:   alu_result = operand1 | operand2;
      OP_XOR:  alu_result = operand1 ^ operand2;
      OP_MOV:  alu_result = operand2;
      OP_CMP:  alu_result = operand1 - operand2;
      OP_COM:  alu_result = ~operand1;
      default: alu_result = '0;
    endcase
    zero_flag = (alu_result == 8'h00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      zero_flag_q <= 1'b0;
    end else begin
      zero_flag_q <= zero_flag;
    end
  end

endmodule

// File: tb/tb_cpu_fetch_decode_alu.sv
// Self-checking bench for cpu_fetch_decode_alu: directed vector table,
// hand-written write/reset sequences and randomized traffic against a model.
module tb_cpu_fetch_decode_alu;

  logic       clk;
  logic       reset;
  logic [3:0] pc;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] operand1;
  logic [7:0] operand2;
  logic [7:0] instruction;
  logic [2:0] opcode;
  logic [2:0] dest;
  logic [2:0] src;
  logic [7:0] alu_result;
  logic       zero_flag;
  logic       zero_flag_q;

  int total;
  int bad;

  cpu_fetch_decode_alu dut (
    .clk(clk), .reset(reset), .pc(pc), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .operand1(operand1), .operand2(operand2),
    .instruction(instruction), .opcode(opcode), .dest(dest), .src(src),
    .alu_result(alu_result), .zero_flag(zero_flag), .zero_flag_q(zero_flag_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] pc;
    logic [7:0] op1;
    logic [7:0] op2;
    logic [7:0] exp_instr;
    logic [7:0] exp_alu;
    logic       exp_zero;
  } vec_t;

  vec_t vecs[12];
  logic [7:0] model_mem [16];
  logic       model_zq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    logic [7:0] img [16];
    img = '{8'hB3, 8'hB6, 8'h01, 8'h21, 8'hC1, 8'h41, 8'h61, 8'h81,
            8'hE0, 8'hA1, 8'h6C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) model_mem[i] = img[i];
    model_zq = 1'b0;
  endfunction

  // Reference ALU from the opcode table using plain integer arithmetic.
  function automatic logic [7:0] model_alu(input logic [2:0] opc, input logic [7:0] a, input logic [7:0] b);
    int x, y, r;
    x = a; y = b;
    case (opc)
      3'd0: r = (x + y) % 256;
      3'd1: r = (x * y) % 256;
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = y;
      3'd6: r = (x - y + 256) % 256;
      default: r = 255 - x;
    endcase
    return r[7:0];
  endfunction

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] w, e;
    logic       do_rst, do_we;
    total = 0; bad = 0;
    reset = 1'b1; pc = '0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    operand1 = '0; operand2 = '0;
    model_reset();

    vecs[0]  = '{4'd2, 8'h03, 8'h02, 8'h01, 8'h05, 1'b0};
    vecs[1]  = '{4'd3, 8'h05, 8'h02, 8'h21, 8'h0A, 1'b0};
    vecs[2]  = '{4'd3, 8'h20, 8'h10, 8'h21, 8'h00, 1'b1};
    vecs[3]  = '{4'd4, 8'h0A, 8'h0A, 8'hC1, 8'h00, 1'b1};
    vecs[4]  = '{4'd4, 8'h0A, 8'h02, 8'hC1, 8'h08, 1'b0};
    vecs[5]  = '{4'd5, 8'hF0, 8'h3C, 8'h41, 8'h30, 1'b0};
    vecs[6]  = '{4'd6, 8'hF0, 8'h3C, 8'h61, 8'hFC, 1'b0};
    vecs[7]  = '{4'd7, 8'hF0, 8'h3C, 8'h81, 8'hCC, 1'b0};
    vecs[8]  = '{4'd8, 8'hF0, 8'h3C, 8'hE0, 8'h0F, 1'b0};
    vecs[9]  = '{4'd9, 8'hF0, 8'h3C, 8'hA1, 8'h3C, 1'b0};
    vecs[10] = '{4'd4, 8'h02, 8'h0A, 8'hC1, 8'hF8, 1'b0};
    vecs[11] = '{4'd8, 8'hFF, 8'h00, 8'hE0, 8'h00, 1'b1};

    @(posedge clk); #1;
    reset = 1'b0;
    chk("reset_zfq", {31'd0, zero_flag_q}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      pc = 4'(i); #1;
      chk($sformatf("default_mem[%0d]", i), {24'd0, instruction}, {24'd0, model_mem[i]});
    end
    pc = 4'd0; #1;
    chk("pc0_opcode", {29'd0, opcode}, 32'd5);
    chk("pc0_dest", {29'd0, dest}, 32'd4);
    chk("pc0_src", {29'd0, src}, 32'd3);

    for (int i = 0; i < 12; i++) begin
      pc = vecs[i].pc; operand1 = vecs[i].op1; operand2 = vecs[i].op2; #1;
      chk($sformatf("vec%0d_instr", i), {24'd0, instruction}, {24'd0, vecs[i].exp_instr});
      chk($sformatf("vec%0d_alu", i), {24'd0, alu_result}, {24'd0, vecs[i].exp_alu});
      chk($sformatf("vec%0d_zero", i), {31'd0, zero_flag}, {31'd0, vecs[i].exp_zero});
    end

    // CMP equal registers zero_flag_q on the next edge, then clears
    pc = 4'd4; operand1 = 8'h0A; operand2 = 8'h0A; #1;
    @(posedge clk); #1;
    chk("cmp_eq_zfq", {31'd0, zero_flag_q}, 32'd1);
    operand2 = 8'h02; #1;
    chk("cmp_ne_alu", {24'd0, alu_result}, 32'h08);
    chk("cmp_ne_zero", {31'd0, zero_flag}, 32'd0);
    chk("cmp_ne_zfq_hold", {31'd0, zero_flag_q}, 32'd1);
    @(posedge clk); #1;
    chk("cmp_ne_zfq", {31'd0, zero_flag_q}, 32'd0);

    // Program write: old data same cycle, new data afterwards
    pc = 4'd11; prog_addr = 4'd11; prog_data = 8'h1D; prog_we = 1'b1; #1;
    chk("wr_same_cycle", {24'd0, instruction}, 32'h00);
    @(posedge clk); #1;
    prog_we = 1'b0; #1;
    chk("wr_next_instr", {24'd0, instruction}, 32'h1D);
    chk("wr_next_opcode", {29'd0, opcode}, 32'd0);
    chk("wr_next_dest", {29'd0, dest}, 32'd7);
    chk("wr_next_src", {29'd0, src}, 32'd1);
    pulse_reset(); #1;
    chk("wr_reset_revert", {24'd0, instruction}, 32'h00);

    // Reset beats write; zero_flag_q cleared although zero_flag was high
    pc = 4'd4; operand1 = 8'h33; operand2 = 8'h33;
    prog_addr = 4'd4; prog_data = 8'hAA; prog_we = 1'b1; reset = 1'b1; #1;
    chk("rstwe_zero_pre", {31'd0, zero_flag}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0; prog_we = 1'b0; #1;
    chk("rstwe_no_write", {24'd0, instruction}, 32'hC1);
    chk("rstwe_zfq", {31'd0, zero_flag_q}, 32'd0);

    // Randomized traffic against the model
    model_reset();
    for (int n = 0; n < 400; n++) begin
      pc = 4'($urandom_range(0, 15));
      operand1 = 8'($urandom);
      operand2 = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        operand2 = operand1;
      end
      do_we  = ($urandom_range(0, 2) == 0);
      do_rst = ($urandom_range(0, 39) == 0);
      prog_we = do_we; reset = do_rst;
      prog_addr = ($urandom_range(0, 1) == 0) ? pc : 4'($urandom_range(0, 15));
      prog_data = 8'($urandom);
      #1;
      w = model_mem[pc];
      e = model_alu(w[7:5], operand1, operand2);
      chk("rnd_instr", {24'd0, instruction}, {24'd0, w});
      chk("rnd_fields", {23'd0, opcode, dest, src}, {23'd0, w[7:5], w[4:2], 1'b0, w[1:0]});
      chk("rnd_alu", {24'd0, alu_result}, {24'd0, e});
      chk("rnd_zero", {31'd0, zero_flag}, {31'd0, (e == 8'h00)});
      if (do_rst) begin
        model_reset();
      end else begin
        if (do_we) model_mem[prog_addr] = prog_data;
        model_zq = (e == 8'h00);
      end
      @(posedge clk); #1;
      chk("rnd_zfq", {31'd0, zero_flag_q}, {31'd0, model_zq});
    end
    prog_we = 1'b0; reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_fetch_decode_alu.md
Name: cpu_fetch_decode_alu

Overview:
- Front end and execute datapath of the 8-bit teaching CPU.
- Contains a 16x8 writable instruction memory that resets to a fixed default program, a combinational instruction decoder, and a combinational 8-bit ALU with a zero flag.
- The PC and the 4-entry register file sit outside this block: PC drives `pc`, and register read data drives `operand1` / `operand2`.
- Also provides a registered copy of the zero flag.

Parameters:
- None. Widths are fixed: data 8, address 4, opcode 3, register field 3.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; restores memory to the default program and clears `zero_flag_q`
- pc  in  4  instruction fetch address
- prog_we  in  1  memory write enable
- prog_addr  in  4  memory write address
- prog_data  in  8  memory write data
- operand1  in  8  register data addressed by `dest`
- operand2  in  8  register data addressed by `src`
- instruction  out  8  `mem[pc]`, combinational
- opcode  out  3  `instruction[7:5]`
- dest  out  3  `instruction[4:2]`
- src  out  3  `{1'b0, instruction[1:0]}`; register index or 2-bit immediate
- alu_result  out  8  ALU output
- zero_flag  out  1  `(alu_result == 8'h00)`, combinational
- zero_flag_q  out  1  `zero_flag` registered each clock

Behaviour:
- Memory: 16 x 8 registers.
  - Read is asynchronous on `pc`.
  - Write on rising clk when `prog_we=1` and `reset=0`; data is visible from the next cycle.
  - Reading the address being written in the same cycle returns the old data.
  - `reset` has priority over `prog_we`.
- Default program loaded at reset (address:data):
  - 0:B3 (MOV R0,#3)
  - 1:B6 (MOV R1,#2)
  - 2:01 (ADD R0,R1)
  - 3:21 (MUL R0,R1)
  - 4:C1 (CMP R0,R1)
  - 5:41 (AND)
  - 6:61 (OR)
  - 7:81 (XOR)
  - 8:E0 (COM R0)
  - 9:A1 (MOV R0,R1)
  - 10:6C (JMP 0)
  - 11-15:00
- Decoder: purely combinational slicing as listed under Ports; no registers.
- ALU: combinational, all results are 8 bits with carry or overflow discarded.
  - 000 ADD: `op1 + op2` mod 256
  - 001 MUL: low 8 bits of `op1 * op2`
  - 010 AND: `op1 & op2`
  - 011 OR: `op1 | op2`
  - 100 XOR: `op1 ^ op2`
  - 101 MOV: `op2`
  - 110 CMP: `op1 - op2` mod 256; zero means equal
  - 111 COM: `~op1`
- `zero_flag` tracks `alu_result` for every opcode, including MOV and CMP.
- `zero_flag_q`: 0 after reset; otherwise loads `zero_flag` on every rising clk.
- Reset mid-operation: memory contents written via `prog_we` are lost. The combinational outputs immediately reflect the default program at `pc` after the reset edge.
- Jump, MOV-immediate, and write-back interpretation happen outside this block. The block only supplies the decoded fields and `alu_result`.
- Total latency is 0 cycles from `pc` or operands to every output except `zero_flag_q`, which has 1 cycle.

Test Plan:
- Reset for 1 cycle, sweep `pc` 0..15 -> `instruction` matches the default table (`pc=0`: B3, `opcode=101`, `dest=100`, `src=011`; `pc=10`: 6C; `pc=12`: 00).
- `pc=2`, `op1=03`, `op2=02` -> `alu_result=05`, `zero_flag=0`. `pc=3`, `op1=05`, `op2=02` -> `0A`. MUL overflow check: `op1=20`, `op2=10` -> `00`, `zero_flag=1`.
- `pc=4` (CMP), `op1=0A`, `op2=0A` -> `alu_result=00`, `zero_flag=1`; next edge `zero_flag_q=1`. Then `op2=02` -> `alu_result=08`, `zero_flag=0`.
- Logic ops with `op1=F0`, `op2=3C`:
  - AND (`pc=5`) -> 30
  - OR (`pc=6`) -> FC
  - XOR (`pc=7`) -> CC
  - COM (`pc=8`) -> 0F
  - MOV (`pc=9`) -> 3C
- Write `prog_addr=11`, `prog_data=8'h1D` with `pc=11` -> same cycle `instruction=00`, next cycle `1D` (`opcode=000`, `dest=111`, `src=001`). Assert reset -> reverts to 00.
- Assert reset and `prog_we` in the same cycle -> no write; `zero_flag_q=0`.
